// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, request/acknowledge instruction-memory read, valid/ready hand-off to decode.
// Optional misaligned-target fault enabled by defining INSTR_FETCH_MISALIGN_CHECK_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus_4_o,
  input  logic        pc_src_i,
  input  logic [31:0] imm_ext_i,
  output logic [31:0] retired_o,
  output logic        fault_o
);

  localparam logic PC_SRC_PLUS_4   = 1'b0;
  localparam logic PC_SRC_PLUS_OFF = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcPlus4_q, pcPlus4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        instrValid_q, instrValid_d;

  logic [31:0] targetPc;
  logic [31:0] nextPc;
  logic        fetchDone;
  logic        consume;
  logic        misaligned;

  assign fetchDone = (state_q == REQ) && imem_ack_i;
  assign consume   = (state_q == HOLD) && instrValid_q && instr_ready_i;
  assign targetPc  = (pc_src_i == PC_SRC_PLUS_OFF) ? (pc_q + imm_ext_i) : (pc_q + 32'd4);

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  assign misaligned = (targetPc[1:0] != 2'b00);
  assign nextPc     = targetPc;
`else
  // Without the checker the low bits are simply dropped so fetch stays word-aligned.
  assign misaligned = 1'b0;
  assign nextPc     = targetPc & 32'hFFFF_FFFC;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pcPlus4_q    <= RESET_PC + 32'd4;
      instr_q      <= '0;
      instrValid_q <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pcPlus4_q    <= pcPlus4_d;
      instr_q      <= instr_d;
      instrValid_q <= instrValid_d;
      retired_q    <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (imem_ack_i) state_d = HOLD;
      HOLD:    if (consume) state_d = misaligned ? FAULT : REQ;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    pcPlus4_d    = pcPlus4_q;
    instr_d      = instr_q;
    instrValid_d = instrValid_q;
    retired_d    = retired_q;
    if (fetchDone) begin
      instr_d      = imem_rdata_i;
      instrValid_d = 1'b1;
    end
    // A faulting consume still records the offending target and counts as retired.
    if (consume) begin
      pc_d         = nextPc;
      pcPlus4_d    = nextPc + 32'd4;
      instrValid_d = 1'b0;
      retired_d    = retired_q + 32'd1;
    end
  end

  always_comb begin
    imem_req_o    = (state_q == REQ);
    imem_addr_o   = pc_q;
    instr_o       = instr_q;
    instr_valid_o = instrValid_q;
    pc_o          = pc_q;
    pc_plus_4_o   = pcPlus4_q;
    retired_o     = retired_q;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    fault_o       = (state_q == FAULT);
`else
    fault_o       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory responder, scoreboard of expected instr/pc, two instances for RESET_PC cases.
// Expectations follow INSTR_FETCH_MISALIGN_CHECK_EN when it is defined.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        instrReady;
  logic        pcSrc;
  logic [31:0] immExt;
  logic        sel;

  logic        req0, valid0, fault0, req1, valid1, fault1;
  logic [31:0] addr0, instr0, pc0, pc40, ret0;
  logic [31:0] addr1, instr1, pc1, pc41, ret1;

  logic        obsReq, obsValid, obsFault;
  logic [31:0] obsAddr, obsInstr, obsPc, obsPc4, obsRetired;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;
  sb_t sbQ[$];

  int          testsRun = 0;
  int          testsFailed = 0;
  int          cycleCount = 0;
  int          lastReqCycle = 0;
  logic [31:0] expPc;
  logic [31:0] expRetired;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk_i(clk), .rst_i(rst0),
    .imem_req_o(req0), .imem_addr_o(addr0), .imem_ack_i(imemAck), .imem_rdata_i(imemRdata),
    .instr_o(instr0), .instr_valid_o(valid0), .instr_ready_i(instrReady),
    .pc_o(pc0), .pc_plus_4_o(pc40), .pc_src_i(pcSrc), .imm_ext_i(immExt),
    .retired_o(ret0), .fault_o(fault0)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk_i(clk), .rst_i(rst1),
    .imem_req_o(req1), .imem_addr_o(addr1), .imem_ack_i(imemAck), .imem_rdata_i(imemRdata),
    .instr_o(instr1), .instr_valid_o(valid1), .instr_ready_i(instrReady),
    .pc_o(pc1), .pc_plus_4_o(pc41), .pc_src_i(pcSrc), .imm_ext_i(immExt),
    .retired_o(ret1), .fault_o(fault1)
  );

  assign obsReq     = sel ? req1   : req0;
  assign obsValid   = sel ? valid1 : valid0;
  assign obsFault   = sel ? fault1 : fault0;
  assign obsAddr    = sel ? addr1  : addr0;
  assign obsInstr   = sel ? instr1 : instr0;
  assign obsPc      = sel ? pc1    : pc0;
  assign obsPc4     = sel ? pc41   : pc40;
  assign obsRetired = sel ? ret1   : ret0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input logic [31:0] rpc);
    checkBit("rstReq", obsReq, 1'b0);
    checkOutput("rstAddr", obsAddr, rpc);
    checkOutput("rstInstr", obsInstr, 32'h0);
    checkBit("rstValid", obsValid, 1'b0);
    checkOutput("rstPc", obsPc, rpc);
    checkOutput("rstPc4", obsPc4, rpc + 32'd4);
    checkOutput("rstRetired", obsRetired, 32'h0);
    checkBit("rstFault", obsFault, 1'b0);
  endtask

  // Expects imem_req already high; acks after 'waits' cycles and checks the delivered instruction.
  task automatic applyStimulus(input int waits, input bit checkSpacing);
    sb_t e;
    checkBit("req", obsReq, 1'b1);
    checkOutput("addr", obsAddr, expPc);
    if (checkSpacing) checkOutput("spacing", 32'(cycleCount - lastReqCycle), 32'd3);
    lastReqCycle = cycleCount;
    for (int i = 0; i < waits; i++) begin
      tick;
      checkBit("reqHeld", obsReq, 1'b1);
      checkOutput("addrHeld", obsAddr, expPc);
    end
    imemAck   = 1'b1;
    imemRdata = memWord(expPc);
    sbQ.push_back('{expPc, memWord(expPc)});
    tick;
    imemAck   = 1'b0;
    imemRdata = $urandom;
    checkBit("validAfterAck", obsValid, 1'b1);
    checkBit("reqDropped", obsReq, 1'b0);
    if (sbQ.size() == 0) begin
      checkOutput("sbUnderflow", 32'h0, 32'h1);
    end else begin
      e = sbQ.pop_front();
      checkOutput("instr", obsInstr, e.instr);
      checkOutput("pc", obsPc, e.pc);
      checkOutput("pcPlus4", obsPc4, e.pc + 32'd4);
    end
  endtask

  // Core sees valid for one cycle, then asserts ready with its next-PC decision.
  task automatic consume(input logic src, input logic [31:0] imm);
    logic [31:0] tgt;
    tick;
    checkBit("validHold", obsValid, 1'b1);
    instrReady = 1'b1;
    pcSrc      = src;
    immExt     = imm;
    tgt = src ? (expPc + imm) : (expPc + 32'd4);
    tick;
    instrReady = 1'b0;
    pcSrc      = 1'($urandom_range(1));
    immExt     = $urandom;
    expRetired = expRetired + 32'd1;
    checkBit("validCleared", obsValid, 1'b0);
    checkOutput("retired", obsRetired, expRetired);
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    if (tgt[1:0] != 2'b00) begin
      expPc = tgt;
      checkBit("fault", obsFault, 1'b1);
      checkOutput("faultPc", obsPc, tgt);
      checkBit("faultNoReq", obsReq, 1'b0);
      return;
    end
`else
    tgt[1:0] = 2'b00;
`endif
    expPc = tgt;
    checkOutput("pcUpdate", obsPc, expPc);
    checkOutput("pcPlus4Update", obsPc4, expPc + 32'd4);
    checkBit("noFault", obsFault, 1'b0);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0;
    imemAck = 1'b0; imemRdata = 32'h0; instrReady = 1'b0; pcSrc = 1'b0; immExt = 32'h0;
    expPc = 32'h0; expRetired = 32'h0;
    repeat (3) tick;
    checkReset(32'h0);

    // First fetch with two wait states
    rst0 = 1'b0;
    tick;
    applyStimulus(2, 1'b0);

    // Sequential fetches 4 and 8 with zero-wait ack, then branch back by -8
    consume(1'b0, 32'h0);
    applyStimulus(0, 1'b0);
    consume(1'b0, 32'h0);
    applyStimulus(0, 1'b1);
    consume(1'b1, 32'hFFFF_FFF8);
    checkOutput("retiredThree", obsRetired, 32'd3);
    applyStimulus(0, 1'b1);
    consume(1'b1, 32'h0000_0010);
    applyStimulus(1, 1'b0);
    consume(1'b1, 32'h0000_0100);
    applyStimulus(0, 1'b0);

    // Stall in HOLD with spurious acks and changing rdata
    for (int i = 0; i < 5; i++) begin
      imemAck   = 1'b1;
      imemRdata = $urandom;
      tick;
      checkOutput("stallInstr", obsInstr, memWord(32'h0000_0110));
      checkOutput("stallPc", obsPc, 32'h0000_0110);
      checkBit("stallValid", obsValid, 1'b1);
      checkBit("stallNoReq", obsReq, 1'b0);
    end
    imemAck = 1'b0;
    consume(1'b1, 32'hFFFF_FEF0);
    applyStimulus(0, 1'b0);

    // Misaligned target from pc=0
    consume(1'b1, 32'h0000_0002);
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      tick;
      checkBit("faultStaysReq", obsReq, 1'b0);
      checkBit("faultStays", obsFault, 1'b1);
      checkBit("faultNoValid", obsValid, 1'b0);
    end
`else
    applyStimulus(0, 1'b0);
`endif

    // Second instance: PC wrap and reset while waiting for ack
    rst0 = 1'b1;
    sel  = 1'b1;
    expPc = 32'hFFFF_FFFC;
    expRetired = 32'h0;
    tick;
    checkReset(32'hFFFF_FFFC);
    rst1 = 1'b0;
    tick;
    applyStimulus(0, 1'b0);
    consume(1'b0, 32'h0);
    checkBit("wrapReq", obsReq, 1'b1);
    checkOutput("wrapAddr", obsAddr, 32'h0);
    tick;
    rst1 = 1'b1;
    tick;
    checkReset(32'hFFFF_FFFC);
    expPc = 32'hFFFF_FFFC;
    expRetired = 32'h0;
    rst1 = 1'b0;
    tick;
    applyStimulus(1, 1'b0);
    consume(1'b0, 32'h0);
    checkOutput("sbDrained", 32'(sbQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
